// File: rtl/spi_flash_slave.sv
// SPI mode-0 slave that emulates a small serial flash with READ, FAST READ,
// PROGRAM, WREN and WRDI commands, sampled entirely in the CLK domain.
module spi_flash_slave #(
    parameter int MEM_DEPTH  = 64,
    parameter int DUMMY_BITS = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       SCLK,
    input  logic       CS_N,
    input  logic       MOSI,
    output logic       MISO,
    output logic       WEL,
    output logic [7:0] LAST_CMD,
    output logic       CMD_ERR
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int DW = (DUMMY_BITS > 1) ? $clog2(DUMMY_BITS) : 1;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, READ, PROG, IGNORE} state_t;
    typedef enum logic [1:0] {OP_READ, OP_FAST, OP_PROG} op_t;

    state_t          state, state_nx;
    op_t             op;
    logic [1:0]      sclk_sync, cs_sync, mosi_sync, fill;
    logic            sclk_d, cs_d, armed;
    logic [2:0]      bit_cnt;
    logic [1:0]      byte_cnt;
    logic [DW-1:0]   dummy_cnt;
    logic [6:0]      shift_in;
    logic [7:0]      shift_out;
    logic [AW-1:0]   addr;
    logic            extra_bits;
    logic [7:0]      mem [MEM_DEPTH];

    logic       sclk_rise, sclk_fall, cs_rise, cs_fall, byte_done;
    logic [7:0] rx_byte;

    // After reset the CS_N synchronizer holds a fake "high"; a fall is only
    // trusted once the real pin has been seen high, so a reset inside a
    // transaction needs a fresh CS_N fall.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sclk_sync <= 2'b00;
            sclk_d    <= 1'b0;
            cs_sync   <= 2'b11;
            cs_d      <= 1'b1;
            mosi_sync <= 2'b00;
            fill      <= 2'b00;
            armed     <= 1'b0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
            sclk_sync <= {sclk_sync[0], SCLK};
            sclk_d    <= sclk_sync[1];
            cs_sync   <= {cs_sync[0], CS_N};
            cs_d      <= cs_sync[1];
            mosi_sync <= {mosi_sync[0], MOSI};
            fill      <= {fill[0], 1'b1};
            if (fill[1] && cs_sync[1])
                armed <= 1'b1;
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[1] & sclk_d;
    assign cs_rise   = cs_sync[1] & ~cs_d;
    assign cs_fall   = ~cs_sync[1] & cs_d & armed;
    assign rx_byte   = {shift_in, mosi_sync[1]};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);

    always_ff @(posedge CLK) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        // NOTE: default first so no path through this block infers a latch.
        state_nx = state;
        if (cs_rise) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_fall) state_nx = CMD;
                CMD:     if (byte_done) begin
                             case (rx_byte)
                                 8'h03, 8'h0B, 8'h02: state_nx = ADDR;
                                 default:             state_nx = IGNORE;
                             endcase
                         end
                ADDR:    if (byte_done && byte_cnt == 2'd2) begin
                             case (op)
                                 OP_FAST: state_nx = (DUMMY_BITS == 0) ? READ : DUMMY;
                                 OP_PROG: state_nx = PROG;
                                 default: state_nx = READ;
                             endcase
                         end
                DUMMY:   if (sclk_rise && dummy_cnt == DW'(DUMMY_BITS - 1)) state_nx = READ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            MISO       <= 1'b0;
            WEL        <= 1'b0;
            LAST_CMD   <= 8'h00;
            CMD_ERR    <= 1'b0;
            op         <= OP_READ;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 2'd0;
            dummy_cnt  <= '0;
            shift_in   <= 7'd0;
            shift_out  <= 8'd0;
            addr       <= '0;
            extra_bits <= 1'b0;
            // NOTE: the array is deliberately reset, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < MEM_DEPTH; i++)
                mem[i] <= 8'(i);
        end else if (cs_rise) begin
            MISO <= 1'b0;
            if (state == PROG)
                WEL <= 1'b0;
            else if (state == IGNORE && !extra_bits) begin
                if (LAST_CMD == 8'h06)      WEL <= 1'b1;
                else if (LAST_CMD == 8'h04) WEL <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: if (cs_fall) begin
                    bit_cnt    <= 3'd0;
                    byte_cnt   <= 2'd0;
                    extra_bits <= 1'b0;
                end
                CMD: if (sclk_rise) begin
                    shift_in <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        LAST_CMD <= rx_byte;
                        case (rx_byte)
                            8'h03:        op <= OP_READ;
                            8'h0B:        op <= OP_FAST;
                            8'h02:        op <= OP_PROG;
                            8'h06, 8'h04: ;
                            default:      CMD_ERR <= 1'b1;
                        endcase
                    end
                end
                ADDR: if (sclk_rise) begin
                    addr    <= {addr[AW-2:0], mosi_sync[1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        byte_cnt <= byte_cnt + 2'd1;
                    if (byte_done && byte_cnt == 2'd2) begin
                        dummy_cnt <= '0;
                        if (op == OP_PROG && !WEL)
                            CMD_ERR <= 1'b1;
                    end
                end
                DUMMY: if (sclk_rise)
                    dummy_cnt <= dummy_cnt + 1'b1;
                READ: if (sclk_fall) begin
                    if (bit_cnt == 3'd0) {MISO, shift_out} <= {mem[addr], 1'b0};
                    else                 {MISO, shift_out} <= {shift_out, 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        addr <= addr + 1'b1;
                end
                PROG: if (sclk_rise) begin
                    shift_in <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    // A partial byte never reaches the array; only the 8th bit commits.
                    if (bit_cnt == 3'd7 && WEL) begin
                        mem[addr] <= rx_byte;
                        addr      <= addr + 1'b1;
                    end
                end
                IGNORE: if (sclk_rise)
                    extra_bits <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_slave.sv
// Directed bench for spi_flash_slave: drives SPI mode-0 transactions with SCLK
// half-periods of 8 CLK and compares against hand-computed expectations.
module tb_spi_flash_slave;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       SCLK = 1'b0;
    logic       CS_N = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO, WEL, CMD_ERR;
    logic [7:0] LAST_CMD;

    int n_vec = 0;
    int n_err = 0;

    localparam int HALF = 8;

    spi_flash_slave #(.MEM_DEPTH(64), .DUMMY_BITS(8)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .SCLK     (SCLK),
        .CS_N     (CS_N),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .WEL      (WEL),
        .LAST_CMD (LAST_CMD),
        .CMD_ERR  (CMD_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Master shifts nbits MSB-first: MOSI set while SCLK low, MISO sampled just before the rise.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            MOSI = tx[i];
            wait_clk(HALF);
            rx[i] = MISO;
            SCLK = 1'b1;
            wait_clk(HALF);
            SCLK = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] tx);
        logic [7:0] rx;
        xfer(tx, 8, rx);
    endtask

    task automatic send_addr(input logic [23:0] a);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
    endtask

    task automatic cs_low;
        wait_clk(2);
        CS_N = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_high;
        wait_clk(HALF);
        CS_N = 1'b1;
        MOSI = 1'b0;
        wait_clk(8);
    endtask

    initial begin
        logic [7:0] rx;

        wait_clk(3);
        RESET_N = 1'b1;
        wait_clk(2);
        check("rst_miso", MISO, 1'b0);
        check("rst_wel", WEL, 1'b0);
        check("rst_last_cmd", LAST_CMD, 8'h00);
        check("rst_cmd_err", CMD_ERR, 1'b0);

        // READ 0x10: four sequential bytes
        cs_low; send(8'h03); send_addr(24'h000010);
        for (int k = 0; k < 4; k++) begin
            xfer(8'h00, 8, rx);
            check($sformatf("read10_b%0d", k), rx, 8'h10 + 8'(k));
        end
        cs_high;
        check("read_last_cmd", LAST_CMD, 8'h03);
        check("read_miso_idle", MISO, 1'b0);

        // WREN, then PROGRAM two bytes at 0x05
        cs_low; send(8'h06); cs_high;
        check("wren_wel", WEL, 1'b1);
        cs_low; send(8'h02); send_addr(24'h000005); send(8'hA5); send(8'h5A); cs_high;
        check("prog_wel_cleared", WEL, 1'b0);
        check("prog_no_err", CMD_ERR, 1'b0);
        cs_low; send(8'h03); send_addr(24'h000005);
        xfer(8'h00, 8, rx); check("readback_5", rx, 8'hA5);
        xfer(8'h00, 8, rx); check("readback_6", rx, 8'h5A);
        cs_high;

        // PROGRAM without WEL is rejected
        cs_low; send(8'h02); send_addr(24'h000003); send(8'hFF); cs_high;
        check("prot_cmd_err", CMD_ERR, 1'b1);
        cs_low; send(8'h03); send_addr(24'h000003);
        xfer(8'h00, 8, rx); check("prot_readback", rx, 8'h03);
        cs_high;

        // FAST READ at the last address wraps to 0
        cs_low; send(8'h0B); send_addr(24'h00003F); send(8'h00);
        xfer(8'h00, 8, rx); check("fast_3f", rx, 8'h3F);
        xfer(8'h00, 8, rx); check("fast_wrap", rx, 8'h00);
        cs_high;
        check("fast_last_cmd", LAST_CMD, 8'h0B);

        // WREN cut short after 5 bits
        cs_low; xfer(8'h06, 5, rx); cs_high;
        check("abort_wren_wel", WEL, 1'b0);

        // PROGRAM aborted after 4 data bits leaves the byte intact
        cs_low; send(8'h06); cs_high;
        check("wren2_wel", WEL, 1'b1);
        cs_low; send(8'h02); send_addr(24'h000008); xfer(8'hF0, 4, rx); cs_high;
        check("abort_prog_wel", WEL, 1'b0);
        cs_low; send(8'h03); send_addr(24'h000008);
        xfer(8'h00, 8, rx); check("abort_prog_byte", rx, 8'h08);
        cs_high;

        // WREN followed by WRDI, and WREN with trailing bits
        cs_low; send(8'h06); cs_high;
        check("wren3_wel", WEL, 1'b1);
        cs_low; send(8'h04); cs_high;
        check("wrdi_wel", WEL, 1'b0);
        cs_low; send(8'h06); send(8'h00); cs_high;
        check("wren_16bit_wel", WEL, 1'b0);

        // Reset in the middle of a READ byte
        cs_low; send(8'h06); cs_high;
        cs_low; send(8'h03); send_addr(24'h000007);
        xfer(8'h00, 6, rx);
        check("midread_partial", rx, 8'h04);
        check("midread_miso_hi", MISO, 1'b1);
        RESET_N = 1'b0;
        wait_clk(1);
        RESET_N = 1'b1;
        check("midrst_miso", MISO, 1'b0);
        check("midrst_wel", WEL, 1'b0);
        check("midrst_cmd_err", CMD_ERR, 1'b0);
        check("midrst_last_cmd", LAST_CMD, 8'h00);
        // CS_N stays low across reset: this traffic must be ignored
        wait_clk(4);
        send(8'h03); send_addr(24'h000007);
        xfer(8'h00, 8, rx); check("post_rst_ignored", rx, 8'h00);
        check("post_rst_last_cmd", LAST_CMD, 8'h00);
        cs_high;
        cs_low; send(8'h03); send_addr(24'h000005);
        xfer(8'h00, 8, rx); check("post_rst_mem_init", rx, 8'h05);
        cs_high;
        check("post_rst_read_cmd", LAST_CMD, 8'h03);

        // Unsupported opcode sets the sticky error
        cs_low; send(8'h9F); send(8'h00); cs_high;
        check("bad_op_err", CMD_ERR, 1'b1);
        check("bad_op_last_cmd", LAST_CMD, 8'h9F);
        check("bad_op_miso", MISO, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
